// File: rtl/cpu_supervisor.sv
// Arbitrates memory between a CPU and a debug monitor; runs HALT/READ/WRITE/RUN monitor commands.
// Latency: WRITE done +2, READ done +3, RUN done +2 cycles from accept; mon_ready only in PARKED/RUNNING.
module cpu_supervisor #(
    parameter int addr_width = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [addr_width-1:0] cpu_raddr,
    input  logic [addr_width-1:0] cpu_waddr,
    input  logic [7:0]            cpu_data_in,
    input  logic                  cpu_write,
    input  logic                  cpu_halted,
    output logic                  cpu_reset,
    output logic                  cpu_halt,
    output logic [addr_width-1:0] cpu_start_address,
    output logic [addr_width-1:0] mem_raddr,
    output logic [addr_width-1:0] mem_waddr,
    output logic [7:0]            mem_data_in,
    output logic                  mem_write,
    input  logic [7:0]            mem_data_out,
    input  logic                  mon_valid,
    input  logic [1:0]            mon_op,
    input  logic [addr_width-1:0] mon_addr,
    input  logic [7:0]            mon_wdata,
    output logic                  mon_ready,
    output logic                  mon_done,
    output logic [7:0]            mon_rdata,
    output logic                  cpu_running,
    output logic                  cpu_stopped
);

    typedef enum logic [2:0] {
        PARKED, RUNNING, HALTING, RD_WAIT, RD_CAP, WR, RELEASE
    } state_t;

    localparam logic [1:0] OP_HALT  = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_RUN   = 2'd3;

    state_t                state_q, state_d;
    logic                  owner_cpu_q, owner_cpu_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  cpu_halt_q, cpu_halt_d;
    logic [addr_width-1:0] start_q, start_d;
    logic [addr_width-1:0] raddr_q, raddr_d;
    logic [addr_width-1:0] waddr_q, waddr_d;
    logic [7:0]            wdata_q, wdata_d;
    logic                  mwrite_q, mwrite_d;
    logic                  done_q, done_d;
    logic [7:0]            rdata_q, rdata_d;
    // Command taken while the CPU ran; replayed from PARKED once ownership returns
    logic                  pend_q, pend_d;
    logic [1:0]            pop_q, pop_d;
    logic [addr_width-1:0] paddr_q, paddr_d;
    logic [7:0]            pwdata_q, pwdata_d;

    logic                  accept;
    logic                  cmd_go;
    logic [1:0]            cmd_op;
    logic [addr_width-1:0] cmd_addr;
    logic [7:0]            cmd_wdata;

    assign mon_ready = ((state_q == PARKED) && !pend_q) || (state_q == RUNNING);
    assign accept    = mon_valid && mon_ready;
    assign cmd_go    = pend_q || accept;
    assign cmd_op    = pend_q ? pop_q    : mon_op;
    assign cmd_addr  = pend_q ? paddr_q  : mon_addr;
    assign cmd_wdata = pend_q ? pwdata_q : mon_wdata;

    always_comb begin
        state_d     = state_q;
        owner_cpu_d = owner_cpu_q;
        cpu_reset_d = cpu_reset_q;
        cpu_halt_d  = cpu_halt_q;
        start_d     = start_q;
        raddr_d     = raddr_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        mwrite_d    = 1'b0;
        done_d      = 1'b0;
        rdata_d     = rdata_q;
        pend_d      = pend_q;
        pop_d       = pop_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        case (state_q)
            PARKED: begin
                if (cmd_go) begin
                    pend_d = 1'b0;
                    case (cmd_op)
                        OP_HALT:  done_d = 1'b1;
                        OP_READ: begin
                            raddr_d = cmd_addr;
                            state_d = RD_WAIT;
                        end
                        OP_WRITE: begin
                            waddr_d = cmd_addr;
                            wdata_d = cmd_wdata;
                            state_d = WR;
                        end
                        default: begin
                            start_d = cmd_addr;
                            state_d = RELEASE;
                        end
                    endcase
                end
            end
            RUNNING: begin
                if (accept) begin
                    pop_d      = mon_op;
                    paddr_d    = mon_addr;
                    pwdata_d   = mon_wdata;
                    cpu_halt_d = 1'b1;
                    state_d    = HALTING;
                end
            end
            HALTING: begin
                if (cpu_halted) begin
                    cpu_halt_d  = 1'b0;
                    cpu_reset_d = 1'b1;
                    owner_cpu_d = 1'b0;
                    state_d     = PARKED;
                    if (pop_q == OP_HALT) done_d = 1'b1;
                    else                  pend_d = 1'b1;
                end
            end
            RD_WAIT: state_d = RD_CAP;
            RD_CAP: begin
                rdata_d = mem_data_out;
                done_d  = 1'b1;
                state_d = PARKED;
            end
            WR: begin
                mwrite_d = 1'b1;
                done_d   = 1'b1;
                state_d  = PARKED;
            end
            RELEASE: begin
                cpu_reset_d = 1'b0;
                owner_cpu_d = 1'b1;
                done_d      = 1'b1;
                state_d     = RUNNING;
            end
            default: state_d = PARKED;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= PARKED;
            owner_cpu_q <= 1'b0;
            cpu_reset_q <= 1'b1;
            cpu_halt_q  <= 1'b0;
            start_q     <= '0;
            raddr_q     <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            mwrite_q    <= 1'b0;
            done_q      <= 1'b0;
            rdata_q     <= '0;
            pend_q      <= 1'b0;
            pop_q       <= OP_HALT;
            paddr_q     <= '0;
            pwdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_cpu_q <= owner_cpu_d;
            cpu_reset_q <= cpu_reset_d;
            cpu_halt_q  <= cpu_halt_d;
            start_q     <= start_d;
            raddr_q     <= raddr_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            mwrite_q    <= mwrite_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            pend_q      <= pend_d;
            pop_q       <= pop_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
        end
    end

    // Ownership mux: the unselected side can never reach the memory port
    assign mem_raddr   = owner_cpu_q ? cpu_raddr   : raddr_q;
    assign mem_waddr   = owner_cpu_q ? cpu_waddr   : waddr_q;
    assign mem_data_in = owner_cpu_q ? cpu_data_in : wdata_q;
    assign mem_write   = owner_cpu_q ? cpu_write   : mwrite_q;

    assign cpu_reset         = cpu_reset_q;
    assign cpu_halt          = cpu_halt_q;
    assign cpu_start_address = start_q;
    assign mon_done          = done_q;
    assign mon_rdata         = rdata_q;
    assign cpu_running       = owner_cpu_q;
    assign cpu_stopped       = owner_cpu_q && cpu_halted;

endmodule

// File: doc/cpu_supervisor.md
CPU_SUPERVISOR -- requirements
Module: cpu_supervisor

Interface
REQ-001 SHALL have parameter addr_width, default 9, width of all memory addresses.
REQ-002 SHALL have ports:
- clk  in  1  single clock; all logic on posedge
- reset  in  1  asynchronous, active-high
- cpu_raddr / cpu_waddr  in  addr_width  CPU read/write address
- cpu_data_in  in  8  CPU write data
- cpu_write  in  1  CPU write strobe
- cpu_halted  in  1  CPU halted flag
- cpu_reset  out  1  CPU synchronous reset
- cpu_halt  out  1  CPU halt request
- cpu_start_address  out  addr_width  CPU start address
- mem_raddr / mem_waddr  out  addr_width  memory addresses
- mem_data_in  out  8  memory write data
- mem_write  out  1  memory write strobe
- mem_data_out  in  8  memory read data; also routed unchanged to CPU
- mon_valid  in  1  monitor command valid
- mon_op  in  2  0=HALT, 1=READ, 2=WRITE, 3=RUN
- mon_addr  in  addr_width  command address
- mon_wdata  in  8  WRITE data
- mon_ready  out  1  command accepted this cycle if mon_valid
- mon_done  out  1  one-cycle completion pulse
- mon_rdata  out  8  READ result
- cpu_running  out  1  CPU owns memory
- cpu_stopped  out  1  cpu_running & cpu_halted (halt instruction executed)

Function
REQ-003 SHALL implement states PARKED, RUNNING, HALTING, RD_WAIT, RD_CAP, WR, RELEASE.
REQ-004 SHALL drive owner select from a register: owner=CPU only in RUNNING and HALTING; mem_raddr/mem_waddr/mem_data_in/mem_write combinationally from cpu_* when owner=CPU, else from monitor registers.
REQ-005 SHALL assert mon_ready only in PARKED and RUNNING; accept = mon_valid & mon_ready; mon_valid outside these states ignored.
REQ-006 SHALL hold cpu_reset=1 in PARKED, RD_WAIT, RD_CAP, WR, RELEASE; 0 in RUNNING, HALTING.
REQ-007 RUNNING accept (any op): latch op/addr/wdata, cpu_halt<=1, go HALTING.
REQ-008 HALTING: stay until cpu_halted=1; then cpu_halt<=0, cpu_reset<=1, owner<=monitor; HALT op -> mon_done, PARKED; other ops dispatch as from PARKED on the next edge.
REQ-009 PARKED HALT op SHALL complete with mon_done next cycle, no other effect.
REQ-010 READ: accept edge registers mon_addr into mem_raddr -> RD_WAIT -> RD_CAP; RD_CAP edge captures mem_data_out into mon_rdata, pulses mon_done, returns PARKED; mon_done high 3 cycles after accept cycle from PARKED.
REQ-011 mon_rdata SHALL hold until next READ capture.
REQ-012 WRITE: accept edge registers mem_waddr/mem_data_in -> WR; WR edge sets mem_write=1 for exactly one cycle with mon_done; back to PARKED.
REQ-013 RUN: accept edge loads cpu_start_address<=mon_addr -> RELEASE (cpu_reset still 1); RELEASE edge sets cpu_reset<=0, owner<=CPU, mon_done, state RUNNING.
REQ-014 cpu_start_address SHALL change only on RUN accept.
REQ-015 Address widths: all addresses addr_width, no wrap logic; full range usable.
REQ-016 mem_write SHALL never be driven by monitor while owner=CPU, nor by CPU while owner=monitor.

Reset
REQ-017 Reset asserted: state PARKED, cpu_reset=1, cpu_halt=0, cpu_start_address=0, mem_raddr=mem_waddr=0, mem_data_in=0, monitor mem_write=0, mon_done=0, mon_rdata=0, owner=monitor.
REQ-018 Reset mid-operation SHALL abort it without mon_done and without a memory write.

Verification
REQ-019 After reset, WRITE addr 0x010 data 0xA5 -> one-cycle mem_write, mem_waddr=0x010, mem_data_in=0xA5, mon_done 2 cycles after accept.
REQ-020 Then READ 0x010 (memory returns stored byte) -> mon_rdata=0xA5, mon_done 3 cycles after accept.
REQ-021 RUN addr 0x020 -> cpu_start_address=0x020, cpu_reset low from cycle 2, cpu_running=1, CPU addresses appear on mem_raddr.
REQ-022 While RUNNING, READ 0x030 -> cpu_halt high until cpu_halted, then cpu_reset=1, read completes, state PARKED, no CPU mem_write after ownership switch.
REQ-023 RUNNING, CPU executes halt instruction -> cpu_stopped=1, mon_ready=1; HALT op -> PARKED, mon_done.
REQ-024 mon_valid held during RD_WAIT with different op -> ignored; reset asserted during WR -> no mem_write pulse.
